aes_round_sequencer: RTL

// - Cycle/round sequencer for the 32-bit column-serial AES core; sits directly upstream of the

---
 rtl/aes_round_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Round/cycle sequencer for the column-serial AES core; optional AES_SEQ_ERR_EN adds protocol checking.
// Latency: first in_ready 1 cycle after start, first out_valid 4*(NR+1)+1 cycles after start.
// Backpressure: none; upstream supplies one word per input cycle, results stream out unstalled.
module aes_round_sequencer #(
  parameter int NR    = 10,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_in,
  input  logic             in_valid,
  output logic             mode,
  output logic             busy,
  output logic             in_ready,
  output logic             out_valid,
  output logic [1:0]       count_cycle,
  output logic [CNT_W-1:0] count_cycle_number,
  output logic             idle_round,
  output logic             input_round,
  output logic             last_round,
  output logic             done_round,
  output logic [3:0]       key_idx,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST_N = CNT_W'(NR + 1);
  localparam logic [CNT_W-1:0] OUT_N  = CNT_W'(NR + 2);

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_INPUT,
    PH_PROC,
    PH_LAST,
    PH_OUT
  } phase_t;

  phase_t           phase;
  logic [CNT_W-1:0] ccn_q, ccn_d;
  logic [1:0]       cc_q, cc_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             abort;
  logic [3:0]       rnd;

  always_comb begin
    phase = PH_PROC;
    if (ccn_q == '0)          phase = PH_IDLE;
    else if (ccn_q == CNT_W'(1)) phase = PH_INPUT;
    else if (ccn_q == LAST_N) phase = PH_LAST;
    else if (ccn_q == OUT_N)  phase = PH_OUT;
  end

`ifdef AES_SEQ_ERR_EN
  // A start is only legal when idle or on the very last output cycle.
  assign abort = (phase == PH_INPUT && !in_valid) ||
                 (start && phase != PH_IDLE && !(phase == PH_OUT && cc_q == 2'd3));
`else
  logic unused_in_valid;
  assign unused_in_valid = in_valid;
  assign abort = 1'b0;
`endif

  always_comb begin
    ccn_d  = ccn_q;
    cc_d   = cc_q;
    mode_d = mode_q;
    err_d  = err_q;
    if (abort) begin
      ccn_d = '0;
      cc_d  = '0;
      err_d = 1'b1;
    end else begin
      case (phase)
        PH_IDLE: begin
          if (start) begin
            ccn_d  = CNT_W'(1);
            cc_d   = '0;
            mode_d = mode_in;
          end
        end
        PH_OUT: begin
          cc_d = cc_q + 2'd1;
          if (cc_q == 2'd3) begin
            if (start) begin
              ccn_d  = CNT_W'(1);
              mode_d = mode_in;
            end else begin
              ccn_d = '0;
            end
          end
        end
        default: begin
          cc_d = cc_q + 2'd1;
          if (cc_q == 2'd3) ccn_d = ccn_q + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccn_q  <= '0;
      cc_q   <= '0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ccn_q  <= ccn_d;
      cc_q   <= cc_d;
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  // Input round maps to index 0 (enc) / NR (dec); round k maps to k-1 / NR-(k-1).
  assign rnd = 4'(ccn_q - CNT_W'(1));

  always_comb begin
    key_idx = 4'd0;
    if (phase == PH_INPUT || phase == PH_PROC || phase == PH_LAST)
      key_idx = mode_q ? (4'(NR) - rnd) : rnd;
  end

  assign count_cycle        = cc_q;
  assign count_cycle_number = ccn_q;
  assign mode               = mode_q;
  assign err                = err_q;
  assign idle_round         = (phase == PH_IDLE);
  assign busy               = (phase != PH_IDLE);
  assign input_round        = (phase == PH_INPUT);
  assign last_round         = (phase == PH_LAST);
  assign done_round         = (phase == PH_OUT);
  assign in_ready           = input_round;
  assign out_valid          = done_round;

endmodule
